crossbar_slave_arbiter: RTL and testbench

//  Per-slave round-robin arbiter for the 2m2s crossbar family; one instance per slave port.

---
 rtl/crossbar_slave_arbiter.sv | 103 ++++++++++
 tb/tb_crossbar_slave_arbiter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/crossbar_slave_arbiter.sv
// Per-slave round-robin arbiter for the 2m2s crossbar family.
// Owns the registered one-hot connection grant for one slave port and holds
// it for a whole transaction: request through slave ack, abort or timeout.
module crossbar_slave_arbiter #(
    parameter int unsigned N_MASTERS = 2,
    parameter int unsigned TIMEOUT   = 0,
    parameter int unsigned TO_W      = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [N_MASTERS-1:0]         req_in,
    input  logic                         slave_ack,
    output logic [N_MASTERS-1:0]         grant,
    output logic                         grant_valid,
    output logic [$clog2(N_MASTERS)-1:0] grant_idx,
    output logic                         timeout_err
);

    localparam int unsigned IDX_W = $clog2(N_MASTERS);
    localparam bit TO_EN = (TIMEOUT != 0);
    // Last GRANTED cycle count before the grant is revoked (unused when TO_EN=0)
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
    localparam logic [TO_W-1:0] CNT_MAX = '1;

    typedef enum logic {
        IDLE,
        GRANTED
    } state_t;

    state_t            state;
    logic [TO_W-1:0]   cnt;
    logic [IDX_W-1:0]  last;

    logic              pick_found;
    logic [IDX_W-1:0]  pick_idx;
    logic [IDX_W-1:0]  cand;
    logic              g_req;
    logic              release_grant;

    // Round-robin pick: first requester scanning last+1, last+2, ... (mod N).
    // Scanning from the far end lets the nearest candidate overwrite the result.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int k = int'(N_MASTERS); k >= 1; k--) begin
            cand = IDX_W'((int'(last) + k) % int'(N_MASTERS));
            if (req_in[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    // Release conditions for the current winner: ack, abort or timeout
    always_comb begin
        g_req         = req_in[grant_idx];
        release_grant = slave_ack || !g_req || (TO_EN && (cnt == TO_LAST));
    end

    // Grant FSM with registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            grant       <= '0;
            grant_valid <= 1'b0;
            grant_idx   <= '0;
            timeout_err <= 1'b0;
            cnt         <= '0;
            last        <= IDX_W'(N_MASTERS - 1);
        end else begin
            timeout_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        state       <= GRANTED;
                        grant       <= N_MASTERS'(1) << pick_idx;
                        grant_valid <= 1'b1;
                        grant_idx   <= pick_idx;
                        cnt         <= '0;
                    end
                end
                GRANTED: begin
                    if (release_grant) begin
                        state       <= IDLE;
                        grant       <= '0;
                        grant_valid <= 1'b0;
                        grant_idx   <= '0;
                        last        <= grant_idx;
                        // Only a release that is neither ack nor abort is a timeout
                        timeout_err <= !slave_ack && g_req;
                    end else if (cnt != CNT_MAX) begin
                        cnt <= cnt + TO_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_crossbar_slave_arbiter.sv
// Bench for crossbar_slave_arbiter: vector table on a 2-master/timeout-4
// instance, ordered sequence on a 4-master instance, and random stimulus on
// 4-master and 3-master/timeout-3 instances against a behavioural model.
module tb_crossbar_slave_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Instance A: 2 masters, TIMEOUT=4
    logic       a_rst, a_ack, a_valid, a_err;
    logic [1:0] a_req, a_grant;
    logic [0:0] a_idx;
    // Instance B: 4 masters, timeout disabled
    logic       b_rst, b_ack, b_valid, b_err;
    logic [3:0] b_req, b_grant;
    logic [1:0] b_idx;
    // Instance C: 3 masters, TIMEOUT=3
    logic       c_rst, c_ack, c_valid, c_err;
    logic [2:0] c_req, c_grant;
    logic [1:0] c_idx;

    crossbar_slave_arbiter #(.N_MASTERS(2), .TIMEOUT(4), .TO_W(8)) dut_a (
        .clk(clk), .rst(a_rst), .req_in(a_req), .slave_ack(a_ack),
        .grant(a_grant), .grant_valid(a_valid), .grant_idx(a_idx), .timeout_err(a_err)
    );
    crossbar_slave_arbiter #(.N_MASTERS(4), .TIMEOUT(0), .TO_W(8)) dut_b (
        .clk(clk), .rst(b_rst), .req_in(b_req), .slave_ack(b_ack),
        .grant(b_grant), .grant_valid(b_valid), .grant_idx(b_idx), .timeout_err(b_err)
    );
    crossbar_slave_arbiter #(.N_MASTERS(3), .TIMEOUT(3), .TO_W(4)) dut_c (
        .clk(clk), .rst(c_rst), .req_in(c_req), .slave_ack(c_ack),
        .grant(c_grant), .grant_valid(c_valid), .grant_idx(c_idx), .timeout_err(c_err)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Behavioural model: who holds the slave, who went last, how long held
    typedef struct {
        bit busy;
        int g;
        int last;
        int cnt;
        bit err;
    } mst_t;

    function automatic mst_t step(input mst_t m, input int n, input int to, input int sat,
                                  input logic [3:0] req, input logic ack, input logic rst);
        mst_t r = m;
        r.err = 1'b0;
        if (rst) begin
            r.busy = 1'b0; r.g = 0; r.last = n - 1; r.cnt = 0;
        end else if (!m.busy) begin
            for (int k = 1; k <= n; k++) begin
                int c = (m.last + k) % n;
                if (req[c]) begin
                    r.busy = 1'b1; r.g = c; r.cnt = 0;
                    break;
                end
            end
        end else if (ack || !req[m.g] || (to != 0 && m.cnt == to - 1)) begin
            r.busy = 1'b0;
            r.last = m.g;
            r.err  = !ack && req[m.g];
        end else if (m.cnt < sat) begin
            r.cnt = m.cnt + 1;
        end
        return r;
    endfunction

    function automatic int m_grant(input mst_t m);
        return m.busy ? (1 << m.g) : 0;
    endfunction

    function automatic int m_idx(input mst_t m);
        return m.busy ? m.g : 0;
    endfunction

    mst_t mb = '{1'b0, 0, 3, 0, 1'b0};
    mst_t mc = '{1'b0, 0, 2, 0, 1'b0};
    bit   model_en = 1'b0;

    // Advance models on the same edge the DUTs see
    always @(posedge clk) begin
        mb <= step(mb, 4, 0, 255, b_req, b_ack, b_rst);
        mc <= step(mc, 3, 3, 15, {1'b0, c_req}, c_ack, c_rst);
    end

    // Compare B and C against the model away from the active edge
    always @(negedge clk) begin
        if (model_en) begin
            chk("b_grant", int'(b_grant), m_grant(mb));
            chk("b_valid", int'(b_valid), int'(mb.busy));
            chk("b_idx",   int'(b_idx),   m_idx(mb));
            chk("b_err",   int'(b_err),   int'(mb.err));
            chk("c_grant", int'(c_grant), m_grant(mc));
            chk("c_valid", int'(c_valid), int'(mc.busy));
            chk("c_idx",   int'(c_idx),   m_idx(mc));
            chk("c_err",   int'(c_err),   int'(mc.err));
        end
    end

    typedef struct {
        logic       rst;
        logic [1:0] req;
        logic       ack;
        logic [1:0] g;
        logic       err;
    } vec_t;

    vec_t vecs[28];

    initial begin
        // {rst, req, ack} applied for one edge, then expected {grant, timeout_err}
        vecs[0]  = '{1'b1, 2'b11, 1'b0, 2'b00, 1'b0};  // reset
        vecs[1]  = '{1'b0, 2'b11, 1'b0, 2'b01, 1'b0};  // master 0 first
        vecs[2]  = '{1'b0, 2'b11, 1'b1, 2'b00, 1'b0};  // ack
        vecs[3]  = '{1'b0, 2'b11, 1'b0, 2'b10, 1'b0};  // rotate to 1
        vecs[4]  = '{1'b0, 2'b11, 1'b1, 2'b00, 1'b0};
        vecs[5]  = '{1'b0, 2'b11, 1'b0, 2'b01, 1'b0};
        vecs[6]  = '{1'b0, 2'b10, 1'b0, 2'b00, 1'b0};  // abort by master 0
        vecs[7]  = '{1'b0, 2'b11, 1'b0, 2'b10, 1'b0};
        vecs[8]  = '{1'b0, 2'b01, 1'b0, 2'b00, 1'b0};  // abort by master 1, no error
        vecs[9]  = '{1'b0, 2'b01, 1'b0, 2'b01, 1'b0};  // pending master 0 wins
        vecs[10] = '{1'b0, 2'b01, 1'b1, 2'b00, 1'b0};
        vecs[11] = '{1'b0, 2'b01, 1'b0, 2'b01, 1'b0};  // lone master re-granted
        vecs[12] = '{1'b0, 2'b01, 1'b1, 2'b00, 1'b0};
        vecs[13] = '{1'b0, 2'b11, 1'b1, 2'b10, 1'b0};  // ack in IDLE ignored
        vecs[14] = '{1'b1, 2'b11, 1'b0, 2'b00, 1'b0};  // reset mid-transaction
        vecs[15] = '{1'b0, 2'b11, 1'b0, 2'b01, 1'b0};  // master 0 first again
        vecs[16] = '{1'b0, 2'b11, 1'b1, 2'b00, 1'b0};
        vecs[17] = '{1'b0, 2'b10, 1'b0, 2'b10, 1'b0};  // timeout run: 4 held cycles
        vecs[18] = '{1'b0, 2'b10, 1'b0, 2'b10, 1'b0};
        vecs[19] = '{1'b0, 2'b10, 1'b0, 2'b10, 1'b0};
        vecs[20] = '{1'b0, 2'b10, 1'b0, 2'b10, 1'b0};
        vecs[21] = '{1'b0, 2'b10, 1'b0, 2'b00, 1'b1};  // revoked with error pulse
        vecs[22] = '{1'b0, 2'b10, 1'b0, 2'b10, 1'b0};  // pulse gone, regrant
        vecs[23] = '{1'b0, 2'b10, 1'b0, 2'b10, 1'b0};
        vecs[24] = '{1'b0, 2'b10, 1'b0, 2'b10, 1'b0};
        vecs[25] = '{1'b0, 2'b10, 1'b0, 2'b10, 1'b0};
        vecs[26] = '{1'b0, 2'b10, 1'b1, 2'b00, 1'b0};  // ack on timeout cycle: no error
        vecs[27] = '{1'b0, 2'b00, 1'b0, 2'b00, 1'b0};

        a_rst = 1'b1; a_req = '0; a_ack = 1'b0;
        b_rst = 1'b1; b_req = '0; b_ack = 1'b0;
        c_rst = 1'b1; c_req = '0; c_ack = 1'b0;
        @(negedge clk);
        tick();
        b_rst = 1'b0;
        c_rst = 1'b0;
        model_en = 1'b1;

        // Vector table on instance A
        foreach (vecs[i]) begin
            a_rst = vecs[i].rst;
            a_req = vecs[i].req;
            a_ack = vecs[i].ack;
            tick();
            chk($sformatf("a_grant[%0d]", i), int'(a_grant), int'(vecs[i].g));
            chk($sformatf("a_valid[%0d]", i), int'(a_valid), int'(vecs[i].g != 2'b00));
            chk($sformatf("a_idx[%0d]", i),   int'(a_idx),   int'(vecs[i].g == 2'b10));
            chk($sformatf("a_err[%0d]", i),   int'(a_err),   int'(vecs[i].err));
        end

        // Four masters all requesting, ack each grant: order 0,1,2,3,0
        for (int i = 0; i < 5; i++) begin
            b_req = 4'hF;
            b_ack = 1'b0;
            tick();
            chk($sformatf("order_grant[%0d]", i), int'(b_grant), 1 << (i % 4));
            b_ack = 1'b1;
            tick();
            chk($sformatf("order_clear[%0d]", i), int'(b_grant), 0);
        end
        // Ack while idle must not disturb the rotation (last winner still 0)
        b_req = 4'h0;
        b_ack = 1'b1;
        tick();
        chk("idle_ack_grant", int'(b_grant), 0);
        b_req = 4'hF;
        b_ack = 1'b0;
        tick();
        chk("after_idle_ack", int'(b_grant), 4'b0010);
        // Timeout disabled: a grant held for a long time is never revoked
        b_req = 4'b0010;
        for (int i = 0; i < 300; i++) tick();
        chk("long_hold_grant", int'(b_grant), 4'b0010);
        chk("long_hold_err",   int'(b_err),   0);

        // Random traffic on B and C, checked every cycle against the model
        for (int i = 0; i < 1500; i++) begin
            for (int b = 0; b < 4; b++)
                if ($urandom_range(7) == 0) b_req[b] = ~b_req[b];
            for (int b = 0; b < 3; b++)
                if ($urandom_range(7) == 0) c_req[b] = ~c_req[b];
            b_ack = ($urandom_range(4) == 0);
            c_ack = ($urandom_range(5) == 0);
            b_rst = ($urandom_range(80) == 0);
            c_rst = ($urandom_range(80) == 0);
            tick();
        end

        model_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
